// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Forwarding selects are only used when HAZARD_FWD_EN is defined.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } mem_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when a writing stage targets a live (non-x0) register matching rs.
    function automatic logic reg_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != REG_ZERO) && (rd == rs);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Execute-stage operand forwarding selects (M result wins over W result).
// Only built when HAZARD_FWD_EN is defined; otherwise the selects are tied off in hazard_unit.
`ifdef HAZARD_FWD_EN
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);

    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (reg_hit(RegWriteM, RdM, Rs1E))
            ForwardAE = FWD_M;
        else if (reg_hit(RegWriteW, RdW, Rs1E))
            ForwardAE = FWD_W;
        if (reg_hit(RegWriteM, RdM, Rs2E))
            ForwardBE = FWD_M;
        else if (reg_hit(RegWriteW, RdW, Rs2E))
            ForwardBE = FWD_W;
    end

endmodule
`endif

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding, load-use/raw stalls, branch flushes,
// memory-wait hold with timeout halt, and saturating debug counters. Build option: HAZARD_FWD_EN.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             Halted,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT) + 1;

    mem_state_t        state;
    logic [WCNT_W-1:0] wait_cnt;
    logic              data_stall;
    logic              mem_stall;
    logic              unused_inputs;

`ifdef HAZARD_FWD_EN
    forward_unit u_forward (
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE)
    );

    assign data_stall = ResultSrcE0
                        && (reg_hit(1'b1, RdE, Rs1D) || reg_hit(1'b1, RdE, Rs2D))
                        && !PCSrcE;
    assign unused_inputs = RegWriteE;
`else
    assign ForwardAE = FWD_RF;
    assign ForwardBE = FWD_RF;

    // Without forwarding, any in-flight E or M write to a Decode source must drain first.
    assign data_stall = (reg_hit(RegWriteE, RdE, Rs1D) || reg_hit(RegWriteE, RdE, Rs2D)
                         || reg_hit(RegWriteM, RdM, Rs1D) || reg_hit(RegWriteM, RdM, Rs2D))
                        && !PCSrcE;
    assign unused_inputs = ^{Rs1E, Rs2E, RdW, RegWriteW, ResultSrcE0};
`endif

    always_comb begin
        mem_stall = (state != HALT) && MemReqM && !MemReadyM;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        // A held pipeline must not flush D/E, or a pending branch would be lost.
        if (state == HALT || mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = data_stall;
            StallD = data_stall;
            FlushD = PCSrcE;
            FlushE = data_stall || PCSrcE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            Halted     <= 1'b0;
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (StallF && StallCount != '1)
                StallCount <= StallCount + CNT_W'(1);
            if ((FlushD || FlushE) && FlushCount != '1)
                FlushCount <= FlushCount + CNT_W'(1);

            case (state)
                IDLE: begin
                    if (mem_stall) begin
                        state    <= WAIT;
                        wait_cnt <= WCNT_W'(1);
                    end
                end
                WAIT: begin
                    if (MemReadyM || !MemReqM) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WCNT_W'(MEM_TIMEOUT - 1)) begin
                        state  <= HALT;
                        Halted <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                HALT: state <= HALT;
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule
